// File: rtl/vga_scanout.sv
// VGA raster generator: free-running h/v counters drive the pixel-source address,
// and sync/blanking are delayed to line up with the pixel data the source returns.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [10:0] HAddress,
  output logic [10:0] VAddress,
  input  logic [11:0] PixelData,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic frame_start;
  } line_t;

  localparam line_t LINE_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0};

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  line_t       line_d;
  line_t       line_q [PIX_LATENCY];
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, frame_start_q;

  // Source contract: the address shown in cycle t is answered on PixelData in
  // cycle t+PIX_LATENCY; no handshake, the source must keep that latency fixed.
  assign HAddress = h_cnt_q;
  assign VAddress = v_cnt_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  // A held scan still feeds the delay line, but with blanking so the pins idle.
  always_comb begin
    line_d = LINE_IDLE;
    if (enable) begin
      line_d.active      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      line_d.hsync       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      line_d.vsync       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      line_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_comb begin
    rgb_d = '0;
    if (line_q[PIX_LATENCY-1].active) begin
      rgb_d = PixelData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      for (int i = 0; i < PIX_LATENCY; i++) begin
        line_q[i] <= LINE_IDLE;
      end
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      line_q[0] <= line_d;
      for (int i = 1; i < PIX_LATENCY; i++) begin
        line_q[i] <= line_q[i-1];
      end
      rgb_q         <= rgb_d;
      hsync_q       <= line_q[PIX_LATENCY-1].hsync;
      vsync_q       <= line_q[PIX_LATENCY-1].vsync;
      frame_start_q <= line_q[PIX_LATENCY-1].frame_start;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch, in clocks.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter PIX_LATENCY, default 1, legal range 1..4: clocks from address out to PixelData valid.
REQ-006 clk  input  1  pixel clock; single clock domain.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 enable  input  1  scan advance enable.
REQ-009 HAddress  output  11  horizontal pixel address to the pixel source.
REQ-010 VAddress  output  11  vertical pixel address to the pixel source.
REQ-011 PixelData  input  12  pixel from source; {R[11:8], G[7:4], B[3:0]}.
REQ-012 vga_r, vga_g, vga_b  output  4 each  colour to DAC.
REQ-013 hsync, vsync  output  1 each  active-low sync.
REQ-014 frame_start  output  1  one-clock pulse aligned with pixel (0,0) at the colour outputs.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = sum of the four horizontal parameters (800); v_cnt SHALL count 0..V_TOTAL-1 (525).
REQ-016 While enable=1: h_cnt increments every clock; at H_TOTAL-1 it wraps to 0 and v_cnt increments; at v_cnt=V_TOTAL-1 with h wrap, v_cnt wraps to 0.
REQ-017 While enable=0: h_cnt and v_cnt hold.
REQ-018 HAddress SHALL equal h_cnt and VAddress SHALL equal v_cnt, combinationally from the registered counters, including during blanking.
REQ-019 active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-020 Raw hsync is low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); raw vsync is low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-021 Raw frame_start is 1 when h_cnt=0, v_cnt=0 and enable=1.
REQ-022 active, raw hsync, raw vsync and raw frame_start SHALL pass through a PIX_LATENCY-stage register delay line; while enable=0 the line loads active=0, hsync=1, vsync=1, frame_start=0.
REQ-023 Each colour output SHALL be registered: when the delayed active=1, {vga_r,vga_g,vga_b} = PixelData; otherwise 0.
REQ-024 hsync, vsync and frame_start SHALL be registered copies of the delay-line outputs. Total latency from counter value to pin is PIX_LATENCY+1 clocks for every output, so colour and sync stay aligned.
REQ-025 Only the PixelData value sampled in the cycle its address is PIX_LATENCY clocks old SHALL be used; PixelData during blanking is ignored.
REQ-026 Counter compares SHALL use 11-bit unsigned arithmetic; no parameter combination with H_TOTAL or V_TOTAL > 2047 is supported.

Reset
REQ-027 With rst_n=0 at a clk edge: h_cnt=0, v_cnt=0, every delay stage cleared (active=0, hsync=1, vsync=1, frame_start=0), colour outputs 0, hsync=1, vsync=1, frame_start=0.
REQ-028 Reset asserted mid-frame SHALL take effect at the next edge regardless of enable; the first clock after release with enable=1 presents address (0,0).

Verification
REQ-029 Reset release, enable=1, PIX_LATENCY=1, source returns PixelData=12'hA5C for address (0,0) -> frame_start=1 and {r,g,b}={A,5,C} exactly 2 clocks after HAddress=0, VAddress=0.
REQ-030 Free-run 2 full frames -> frame_start period exactly 420000 clocks; hsync low 96 clocks of every 800; vsync low for 1600 consecutive clocks per frame.
REQ-031 PixelData held at 12'hFFF constantly -> colour outputs nonzero only for 640x480 pixels per frame; all zero during h_cnt>=640 or v_cnt>=480 (delayed by latency).
REQ-032 enable dropped for 10 clocks at h_cnt=300, v_cnt=100 -> addresses hold at (300,100); colour 0 and syncs 1 for 10 clocks after latency; scan resumes at (301,100).
REQ-033 rst_n pulsed low for 1 clock at h_cnt=700, v_cnt=490 (inside vsync) -> next clock address (0,0), vsync=1, hsync=1, colour 0.
REQ-034 PIX_LATENCY=3, source modelled as a 3-stage pipeline returning {h[3:0],v[3:0],4'h0} -> every visible output pixel matches its own coordinates, with no off-by-one at h=0, h=639, v=0 or v=479.
